// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Shares the register-file write port (we3/wa3/wd3) between the in-order
//   pipeline writeback and a secondary multi-cycle result source. Secondary
//   results that cannot be written right away wait in a small FIFO. Reads of
//   registers that still have a buffered write outstanding are flagged on
//   hit1/hit2 so the hazard unit can stall.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   p_we/p_wa/p_wd        pipeline writeback request
//   p_stall               pipeline write not taken this cycle
//   s_valid/s_wa/s_wd     secondary write offer
//   s_ready               secondary offer accepted this cycle
//   ra1, ra2              register-file read addresses
//   hit1, hit2            a live buffered write targets ra1 / ra2
//   s_pending             FIFO holds at least one entry
//   we3/wa3/wd3           register-file write port
module rf_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_we,
    input  logic [4:0]  p_wa,
    input  logic [31:0] p_wd,
    output logic        p_stall,
    input  logic        s_valid,
    input  logic [4:0]  s_wa,
    input  logic [31:0] s_wd,
    output logic        s_ready,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic        hit1,
    output logic        hit2,
    output logic        s_pending,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [31:0] wd3
);
    localparam int         PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [DEPTH-1:0]           live_q, live_d;
    logic [DEPTH-1:0][4:0]      wa_q, wa_d;
    logic [DEPTH-1:0][31:0]     wd_q, wd_d;
    logic [PW:0]                rd_ptr_q, rd_ptr_d;
    logic [PW:0]                wr_ptr_q, wr_ptr_d;
    logic [3:0]                 starve_q, starve_d;

    logic [PW-1:0] rd_idx, wr_idx;
    logic          empty, full, head_live, pv;
    logic          grant_pipe, grant_head, pop, bypass, push;

    always_comb begin
        live_d     = live_q;
        wa_d       = wa_q;
        wd_d       = wd_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        starve_d   = starve_q;
        grant_pipe = 1'b0;
        grant_head = 1'b0;
        pop        = 1'b0;
        bypass     = 1'b0;
        p_stall    = 1'b0;
        we3        = 1'b0;
        wa3        = '0;
        wd3        = '0;
        hit1       = 1'b0;
        hit2       = 1'b0;

        rd_idx    = rd_ptr_q[PW-1:0];
        wr_idx    = wr_ptr_q[PW-1:0];
        empty     = (rd_ptr_q == wr_ptr_q);
        full      = (rd_ptr_q[PW] != wr_ptr_q[PW]) && (rd_idx == wr_idx);
        head_live = !empty && live_q[rd_idx];
        pv        = p_we && (p_wa != 5'd0);

        // Grant priority: drop a killed head for free, else live head vs pipe
        // (pipe wins until the head has starved long enough), else bypass.
        if (!empty && !head_live) begin
            pop        = 1'b1;
            grant_pipe = pv;
        end else if (head_live) begin
            if (pv && starve_q != SMAX) begin
                grant_pipe = 1'b1;
            end else begin
                grant_head = 1'b1;
                pop        = 1'b1;
                p_stall    = pv;
            end
        end else if (pv) begin
            grant_pipe = 1'b1;
        end else if (s_valid && s_wa != 5'd0) begin
            bypass = 1'b1;
        end

        // A pop this cycle never frees a slot for a same-cycle push.
        s_ready = !full;
        push    = s_valid && s_ready && (s_wa != 5'd0) && !bypass;

        if (grant_pipe) begin
            we3 = 1'b1;
            wa3 = p_wa;
            wd3 = p_wd;
        end else if (grant_head) begin
            we3 = 1'b1;
            wa3 = wa_q[rd_idx];
            wd3 = wd_q[rd_idx];
        end else if (bypass) begin
            we3 = 1'b1;
            wa3 = s_wa;
            wd3 = s_wd;
        end

        // Hits look at current state only; popped slots have live cleared.
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && ra1 != 5'd0 && wa_q[i] == ra1) hit1 = 1'b1;
            if (live_q[i] && ra2 != 5'd0 && wa_q[i] == ra2) hit2 = 1'b1;
        end

        // Buffered entries are older than a granted pipeline write to the
        // same register, so they must never land after it.
        if (grant_pipe) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wa_q[i] == p_wa) live_d[i] = 1'b0;
            end
        end

        if (pop) begin
            live_d[rd_idx] = 1'b0;
            rd_ptr_d       = rd_ptr_q + 1'b1;
        end

        if (push) begin
            wa_d[wr_idx]   = s_wa;
            wd_d[wr_idx]   = s_wd;
            live_d[wr_idx] = !(grant_pipe && p_wa == s_wa);
            wr_ptr_d       = wr_ptr_q + 1'b1;
        end

        if (pop || empty) starve_d = '0;
        else if (head_live) starve_d = (starve_q == SMAX) ? SMAX : starve_q + 4'd1;

        s_pending = !empty;

        // Inputs are ignored and outputs quiet while reset is asserted.
        if (reset) begin
            p_stall   = 1'b0;
            s_ready   = 1'b0;
            hit1      = 1'b0;
            hit2      = 1'b0;
            s_pending = 1'b0;
            we3       = 1'b0;
            wa3       = '0;
            wd3       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            live_q   <= '0;
            wa_q     <= '0;
            wd_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            starve_q <= '0;
        end else begin
            live_q   <= live_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            starve_q <= starve_d;
        end
    end
endmodule
